jk_universal_reg: RTL

WIDTH-bit register built from JK-style bit cells, with four selectable modes: per-bit JK update, shift left, shift right and up/down count. It is the parametrised successor to the single-bit JK flip-flop. It adds an asynchronous active-low reset, a synchronous clear, an enable, serial I/O and a terminal-count flag. Used as a general state/counter register in the lab datapaths.

---
 rtl/jk_pkg.sv | 14 +
 rtl/jk_bit.sv | 24 ++
 rtl/jk_universal_reg.sv | 87 ++++++++
 3 files changed

// File: rtl/jk_pkg.sv
`default_nettype none
// ==========================================================================
// jk_pkg : mode encodings shared by the JK universal register
// Revision: 1.0
// ==========================================================================
package jk_pkg;

   localparam logic [1:0] MODE_JK  = 2'b00;
   localparam logic [1:0] MODE_SHL = 2'b01;
   localparam logic [1:0] MODE_SHR = 2'b10;
   localparam logic [1:0] MODE_CNT = 2'b11;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_bit.sv
`default_nettype none
// ==========================================================================
// jk_bit : combinational JK next-state cell (hold / clear / set / toggle)
// Revision: 1.0
// ==========================================================================
module jk_bit (
   input  logic q,
   input  logic j,
   input  logic k,
   output logic q_next
);

   always_comb begin
      q_next = q;
      case ({j, k})
         2'b00:   q_next = q;
         2'b01:   q_next = 1'b0;
         2'b10:   q_next = 1'b1;
         default: q_next = ~q;
      endcase
   end

endmodule : jk_bit
`default_nettype wire

// File: rtl/jk_universal_reg.sv
`default_nettype none
// ==========================================================================
// jk_universal_reg : WIDTH-bit JK / shift-left / shift-right / count register
// Revision: 1.0
// ==========================================================================
module jk_universal_reg
   import jk_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             ser_in,
   input  logic             up_dn,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             tc
);

   logic [WIDTH-1:0] jk_next;
   logic [WIDTH-1:0] shl_next;
   logic [WIDTH-1:0] shr_next;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] q_next;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         jk_bit u_bit (
            .q      (q[i]),
            .j      (j[i]),
            .k      (k[i]),
            .q_next (jk_next[i])
         );
      end

      // A single-bit register has no neighbours, so both shifts just load ser_in
      if (WIDTH > 1) begin : g_shift_wide
         assign shl_next = {q[WIDTH-2:0], ser_in};
         assign shr_next = {ser_in, q[WIDTH-1:1]};
      end else begin : g_shift_one
         assign shl_next = ser_in;
         assign shr_next = ser_in;
      end
   endgenerate

   assign cnt_next = up_dn ? (q + WIDTH'(1)) : (q - WIDTH'(1));

   always_comb begin
      q_next = jk_next;
      case (mode)
         MODE_SHL: q_next = shl_next;
         MODE_SHR: q_next = shr_next;
         MODE_CNT: q_next = cnt_next;
         default:  q_next = jk_next;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RESET_VAL;
      end else if (clr) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= q_next;
      end
   end

   always_comb begin
      ser_out = 1'b0;
      case (mode)
         MODE_SHL: ser_out = q[WIDTH-1];
         MODE_SHR: ser_out = q[0];
         default:  ser_out = 1'b0;
      endcase
   end

   // Flags the count that will wrap on the next enabled edge; a pending clear masks it
   assign tc = (mode == MODE_CNT) && en && !clr && (up_dn ? (&q) : (~|q));

endmodule : jk_universal_reg
`default_nettype wire
